rf_write_arbiter: RTL

Owns the single write port (WE/rd/data) of the 32x128 SIMD register file. It shares that port between two requesters: the ALU writeback stage, buffered in a small FIFO, and a host/loader port used for preload and debug. It keeps a pending-write scoreboard and stalls the issue stage on read-after-write hazards against the sources of the opcode being issued.

---
 rtl/rf_write_arbiter_if.sv | 31 +++
 rtl/rf_write_arbiter.sv | 74 +++++++
 2 files changed

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: ALU/host write requests, issue hazard query and register-file write port
interface rf_write_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 128,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          host_valid;
    logic          host_ready;
    logic [AW-1:0] host_rd;
    logic [DW-1:0] host_data;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic          iss_valid;
    logic [24:0]   iss_opcode;
    logic          stall;
    logic [CW-1:0] fifo_count;
    modport master (
        output alu_valid, alu_rd, alu_data, host_valid, host_rd, host_data, iss_valid, iss_opcode,
        input  alu_ready, host_ready, rf_we, rf_rd, rf_data, stall, fifo_count
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, host_valid, host_rd, host_data, iss_valid, iss_opcode,
        output alu_ready, host_ready, rf_we, rf_rd, rf_data, stall, fifo_count
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between a FIFO-buffered ALU writeback
// and a host port, with a pending-write scoreboard that stalls issue on RAW hazards
module rf_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 128,
    parameter int AW    = 5
) (
    input logic clk,
    input logic rst,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0]     q_rd   [DEPTH];
    logic [DW-1:0]     q_data [DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [PW:0]       cnt;
    logic              alu_first;
    logic              we_q;
    logic [AW-1:0]     rd_q;
    logic [DW-1:0]     data_q;
    logic              full, empty, push, gh, ga;
    logic [2**AW-1:0]  pending;
    logic [4:0]        s0;
    logic              unused;
    assign full  = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign push  = bus.alu_valid & ~full;
    // ALU head loses a contested cycle only when it was granted the previous contest
    assign gh    = bus.host_valid & (empty | ~alu_first);
    assign ga    = ~empty & ~gh;
    assign bus.alu_ready  = ~full;
    assign bus.host_ready = gh & ~rst;
    assign bus.fifo_count = cnt;
    assign bus.rf_we      = we_q;
    assign bus.rf_rd      = rd_q;
    assign bus.rf_data    = data_q;
    assign s0     = bus.iss_opcode[24] ? bus.iss_opcode[9:5] : bus.iss_opcode[4:0];
    assign unused = ^bus.iss_opcode[23:20];
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if ((PW+1)'(i) < cnt) pending[q_rd[rp + PW'(i)]] = 1'b1;
        if (we_q) pending[rd_q] = 1'b1;
    end
    assign bus.stall = ~rst & bus.iss_valid &
                       (pending[s0] | pending[bus.iss_opcode[14:10]] | pending[bus.iss_opcode[19:15]]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            alu_first <= 1'b1;
            we_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (ga) rp <= rp + 1'b1;
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(ga);
            if (bus.host_valid & ~empty) alu_first <= gh;
            we_q <= gh | ga;
            if (gh | ga) begin
                rd_q   <= gh ? bus.host_rd : q_rd[rp];
                data_q <= gh ? bus.host_data : q_data[rp];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wp]   <= bus.alu_rd;
            q_data[wp] <= bus.alu_data;
        end
    end
endmodule
